// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width derivation, read-mode constants, wrapping pointer increment.
// Latency: n/a (compile-time constants and pure functions).
// Backpressure: n/a.
package fifo_pkg;

    localparam int FIFO_MODE_STANDARD = 0;
    localparam int FIFO_MODE_FWFT     = 1;

    // Bits needed to hold a count of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Compare-and-wrap so non-power-of-two depths cycle through exactly 0..depth-1.
    function automatic int ptr_inc_wrap(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flex_if.sv
// Push/pop handshake bundle between a producer/consumer (master) and the FIFO (slave).
// Latency: n/a (wires only).
// Backpressure: none carried here; the FIFO reports full/empty on its own status ports.
interface fifo_sync_flex_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;

    modport master (
        output write_enable, write_data, read_enable,
        input  read_data, read_valid
    );

    modport slave (
        input  write_enable, write_data, read_enable,
        output read_data, read_valid
    );
endinterface

// File: rtl/fifo_sync_memory.sv
// Storage array for the single-clock FIFO: DEPTH words of DATA_WIDTH bits.
// Latency: write lands on the clock edge; read is combinational from read_addr.
// Backpressure: none; the caller only asserts write_en for accepted pushes.
// Ports: clock, write_en/write_addr/write_data (sync write), read_addr/read_data (async read).
module fifo_sync_memory
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    // Contents are deliberately not reset; the pointers define what is valid.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with any depth >= 2, standard or first-word-fall-through reads, level and error flags.
// Latency: standard mode read_data/read_valid one cycle after an accepted read; FWFT head visible one cycle after write.
// Backpressure: writes refused when full (standard mode allows full+read), reads refused when empty; refusals set sticky flags.
// Ports: clock/reset, bus (push/pop handshake), threshold inputs, clear_errors, status flags, fill_level, overflow/underflow.
module fifo_sync_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int FWFT        = FIFO_MODE_STANDARD,
    parameter int LEVEL_WIDTH = level_width(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    fifo_sync_flex_if.slave        bus,
    input  logic [LEVEL_WIDTH-1:0] almost_full_threshold,
    input  logic [LEVEL_WIDTH-1:0] almost_empty_threshold,
    input  logic                   clear_errors,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [LEVEL_WIDTH-1:0] fill_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_WIDTH = ptr_width(DEPTH);

    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic                   rd_acc;
    logic                   wr_acc;
    logic [LEVEL_WIDTH-1:0] level_next;
    logic [DATA_WIDTH-1:0]  mem_rd_data;

    always_comb begin
        rd_acc = bus.read_enable && !fifo_empty;
        // In FWFT mode the head word is already presented, so a full FIFO
        // cannot free a slot for a same-cycle write.
        if (FWFT == FIFO_MODE_FWFT) begin
            wr_acc = bus.write_enable && !fifo_full;
        end else begin
            wr_acc = bus.write_enable && (!fifo_full || rd_acc);
        end

        level_next = fill_level;
        if (wr_acc && !rd_acc) begin
            level_next = fill_level + LEVEL_WIDTH'(1);
        end else if (rd_acc && !wr_acc) begin
            level_next = fill_level - LEVEL_WIDTH'(1);
        end
    end

    // Flags are derived from level_next so they line up with fill_level exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PTR_WIDTH'(ptr_inc_wrap(int'(wr_ptr), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= PTR_WIDTH'(ptr_inc_wrap(int'(rd_ptr), DEPTH));
            end
            fill_level   <= level_next;
            fifo_full    <= (level_next == LEVEL_WIDTH'(DEPTH));
            fifo_empty   <= (level_next == '0);
            almost_full  <= (level_next >= almost_full_threshold);
            almost_empty <= (level_next <= almost_empty_threshold);

            // A new error in the same cycle as clear_errors keeps the flag set.
            if (bus.write_enable && !wr_acc) begin
                overflow <= 1'b1;
            end else if (clear_errors) begin
                overflow <= 1'b0;
            end
            if (bus.read_enable && !rd_acc) begin
                underflow <= 1'b1;
            end else if (clear_errors) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_sync_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clock      (clock),
        .write_en   (wr_acc && !reset),
        .write_addr (wr_ptr),
        .write_data (bus.write_data),
        .read_addr  (rd_ptr),
        .read_data  (mem_rd_data)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Zero while empty so stale memory never shows after reset or drain.
            assign bus.read_data  = fifo_empty ? '0 : mem_rd_data;
            assign bus.read_valid = !fifo_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] read_data_q;
            logic                  read_valid_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    read_data_q  <= '0;
                    read_valid_q <= 1'b0;
                end else begin
                    read_valid_q <= rd_acc;
                    if (rd_acc) begin
                        read_data_q <= mem_rd_data;
                    end
                end
            end

            assign bus.read_data  = read_data_q;
            assign bus.read_valid = read_valid_q;
        end
    endgenerate

endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
Single-clock, parametrised FIFO. It is the same-clock successor to the dual-clock FIFO top. It adds:
- arbitrary (non-power-of-two) depth
- selectable standard or first-word-fall-through (FWFT) read mode
- fill-level output and programmable almost-full/almost-empty flags
- sticky overflow/underflow error flags

It is used wherever producer and consumer share one clock domain, e.g. packet staging ahead of the async FIFO.

Parameters:
DATA_WIDTH, 8, width of each data word.
DEPTH, 16, number of entries; any integer >= 2, power of two not required.
FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
LEVEL_WIDTH, $clog2(DEPTH+1), width of fill_level and the threshold ports (derived; do not override).

Ports:
clock  input  1  single clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
write_enable  input  1  push request.
write_data  input  DATA_WIDTH  data to push.
read_enable  input  1  pop request.
read_data  output  DATA_WIDTH  popped data (standard mode) or head-of-queue data (FWFT mode).
read_valid  output  1  standard mode: read_data is valid this cycle. FWFT mode: equals !fifo_empty.
fifo_full  output  1  fill_level == DEPTH.
fifo_empty  output  1  fill_level == 0.
almost_full_threshold  input  LEVEL_WIDTH  almost_full asserts at fill_level >= this value.
almost_empty_threshold  input  LEVEL_WIDTH  almost_empty asserts at fill_level <= this value.
almost_full  output  1  registered almost-full flag.
almost_empty  output  1  registered almost-empty flag.
fill_level  output  LEVEL_WIDTH  number of stored entries, 0..DEPTH.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.
clear_errors  input  1  one-cycle pulse that clears overflow and underflow.

Behaviour:
- Reset (reset=1 at a rising edge): read/write pointers, fill_level, overflow, underflow, read_valid and read_data all go to 0. fifo_empty=1, fifo_full=0, almost_full=0, almost_empty=1. Memory contents are not cleared.
- Reset has priority over every other input.
- A reset asserted mid-operation discards all stored data within one cycle.
- Accepted write: write_enable && (!fifo_full || read_accepted).
  - In standard mode, a write while full is accepted only if a read is accepted in the same cycle.
  - In FWFT mode, a write while full is never accepted, even alongside a read.
- Accepted read: read_enable && !fifo_empty.
  - A read on empty is never accepted, even alongside a write.
- Rejected write sets overflow. Rejected read sets underflow.
  - Both flags stay set until clear_errors or reset.
  - If clear_errors and a new error occur in the same cycle, the error wins (flag stays set).
- Pointers advance 0..DEPTH-1 and wrap to 0 after DEPTH-1. Use a compare-and-wrap, not modulo-2^n.
- fill_level, one update per cycle:
  - +1 on write only
  - -1 on read only
  - unchanged on simultaneous accepted read and write, or on neither
  - never exceeds DEPTH and never underflows.
- Flags (fifo_full, fifo_empty, almost_full, almost_empty) are registered and computed from the next-state fill_level, so they are exact in the same cycle fill_level updates. No extra lag.
- Standard mode (FWFT=0):
  - An accepted read loads read_data from the memory at the read pointer on that edge.
  - read_valid=1 for exactly the following cycle (1-cycle latency).
  - read_data holds its value when no read occurs.
- FWFT mode (FWFT=1):
  - read_data continuously shows the entry at the read pointer.
  - read_valid = !fifo_empty.
  - An accepted read advances to the next entry on the following cycle.
  - A write into an empty FIFO is visible on read_data, with read_valid=1, one cycle after the write edge.
- Threshold ports are sampled every cycle and may change at any time; the flags follow on the next edge.
- A threshold of 0 for almost_full makes the flag permanently 1. A threshold >= DEPTH for almost_empty makes the flag permanently 1. Both are legal.
- Memory writes occur on the edge of the accepted write, at the write pointer.

Decomposition:
- Shared package fifo_pkg holds:
  - clog2-based width helper function
  - FIFO mode constants: FIFO_MODE_STANDARD=0, FIFO_MODE_FWFT=1
  - the pointer-increment-with-wrap function, shared with the future multi-channel FIFO.
- One sub-module: fifo_sync_memory.
  - Parametrised register array: DATA_WIDTH x DEPTH.
  - Synchronous write, asynchronous read port.
  - The top-level adds the output register in standard mode.

Test Plan:
1. DEPTH=16, FWFT=0: write 0x01..0x10 → fifo_full=1 and fill_level=16 on the edge of the 16th write. Then read 16 times → data 0x01..0x10 in order, each with read_valid one cycle after read_enable. fifo_empty=1 after the last read.
2. DEPTH=5 (non-power-of-two): loop 3 writes then 3 reads, 4 iterations (exercises pointer wrap) → data order preserved; fill_level returns to 0 each loop; no overflow or underflow.
3. Full FIFO, DEPTH=16:
   - FWFT=0: simultaneous write 0xAA and read → both accepted, fill_level stays 16, overflow=0.
   - FWFT=1: same stimulus → write rejected, overflow=1, fill_level=15.
4. Empty FIFO: read_enable=1 → underflow=1 and persists. clear_errors pulse → 0. clear_errors together with a new read-on-empty → underflow stays 1.
5. FWFT=1, empty FIFO: write 0x5C → the next cycle read_data=0x5C and read_valid=1 with no read_enable. Read → fifo_empty=1 the next cycle.
6. almost_full_threshold=12, almost_empty_threshold=3: fill from 0 to 16 → almost_empty drops when fill_level goes 3→4 and almost_full rises when fill_level goes 11→12. Assert reset at fill_level=9 → all outputs at reset values after one edge.
